// File: rtl/echo_indication_serializer.sv
// echo_indication_serializer
//   Buffers echo(v) indication calls in a small FIFO and serializes each one
//   into a framed 32-bit word stream for the host indication portal.
//   Message layout: header {METHOD_ID, payload word count}, then the payload
//   word v. When ECHO_IND_SEQ_EN is defined, a running sequence count word is
//   inserted between header and payload. The header count becomes 2.
// Ports
//   CLK        clock, all state on rising edge
//   nRST       asynchronous active-low reset
//   echo__ENA  indication call strobe, effective only while echo__RDY=1
//   echo_v     indication argument
//   echo__RDY  FIFO not full
//   msg_valid  msg_data holds a valid stream word
//   msg_data   stream word
//   msg_ready  consumer accepts the word when msg_valid & msg_ready
//   msg_last   final word of a message
//   drop_err   sticky: a call arrived while echo__RDY=0
module echo_indication_serializer #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] METHOD_ID = 16'd0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        echo__ENA,
  input  logic [31:0] echo_v,
  output logic        echo__RDY,
  output logic        msg_valid,
  output logic [31:0] msg_data,
  input  logic        msg_ready,
  output logic        msg_last,
  output logic        drop_err
);
  localparam int AW = $clog2(DEPTH);

`ifdef ECHO_IND_SEQ_EN
  localparam logic [15:0] LEN = 16'd2;
  typedef enum logic [1:0] {IDLE, HDR, SEQ, PAY} state_t;
  logic [31:0] seq_cnt;
`else
  localparam logic [15:0] LEN = 16'd1;
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;
`endif

  state_t      state, state_n;
  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic        full, wr_en, accept, pop, has_next;
  logic        valid_n, last_n;
  logic [31:0] data_n;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign echo__RDY = ~full;
  assign wr_en     = echo__ENA & ~full;
  assign accept    = msg_valid & msg_ready;
  assign pop       = accept && (state == PAY);
  assign wr_ptr_n  = wr_ptr + (AW+1)'(wr_en);
  assign rd_ptr_n  = rd_ptr + (AW+1)'(pop);
  // Occupancy after this edge's write and pop: lets a fresh call into an
  // empty FIFO and the next queued message start without a bubble.
  assign has_next  = (wr_ptr_n != rd_ptr_n);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (has_next) state_n = HDR;
`ifdef ECHO_IND_SEQ_EN
      HDR:  if (accept) state_n = SEQ;
      SEQ:  if (accept) state_n = PAY;
`else
      HDR:  if (accept) state_n = PAY;
`endif
      PAY:  if (accept) state_n = has_next ? HDR : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output words are produced from the next state so they are registered and
  // appear in the same cycle the FSM enters that state. While stalled the
  // state and head entry are unchanged, so the registers reload identical values.
  always_comb begin
    valid_n = (state_n != IDLE);
    last_n  = (state_n == PAY);
    data_n  = 32'd0;
    case (state_n)
      HDR:     data_n = {METHOD_ID, LEN};
`ifdef ECHO_IND_SEQ_EN
      SEQ:     data_n = seq_cnt;
`endif
      PAY:     data_n = mem[rd_ptr[AW-1:0]];
      default: data_n = 32'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      msg_valid <= 1'b0;
      msg_last  <= 1'b0;
      msg_data  <= 32'd0;
      drop_err  <= 1'b0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      msg_valid <= valid_n;
      msg_last  <= last_n;
      msg_data  <= data_n;
      drop_err  <= drop_err | (echo__ENA & full);
    end
  end

`ifdef ECHO_IND_SEQ_EN
  // Counts completed messages; wraps naturally at 32 bits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)    seq_cnt <= 32'd0;
    else if (pop) seq_cnt <= seq_cnt + 32'd1;
  end
`endif

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= echo_v;
  end
endmodule

// File: tb/tb_echo_indication_serializer.sv
// Directed bench for echo_indication_serializer (DEPTH=4, METHOD_ID=0).
// Expected stream words are built by the bench from the values it calls with.
module tb_echo_indication_serializer;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        echo__ENA = 1'b0;
  logic [31:0] echo_v = 32'd0;
  logic        echo__RDY;
  logic        msg_valid;
  logic [31:0] msg_data;
  logic        msg_ready = 1'b0;
  logic        msg_last;
  logic        drop_err;

  echo_indication_serializer dut (
    .CLK(CLK), .nRST(nRST), .echo__ENA(echo__ENA), .echo_v(echo_v),
    .echo__RDY(echo__RDY), .msg_valid(msg_valid), .msg_data(msg_data),
    .msg_ready(msg_ready), .msg_last(msg_last), .drop_err(drop_err)
  );

  always #5 CLK = ~CLK;

`ifdef ECHO_IND_SEQ_EN
  localparam logic [31:0] HDR = 32'h0000_0002;
`else
  localparam logic [31:0] HDR = 32'h0000_0001;
`endif

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] eq_d[$];
  logic        eq_l[$];
  logic [31:0] seq_m = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic exp_msg(input logic [31:0] v);
    eq_d.push_back(HDR); eq_l.push_back(1'b0);
`ifdef ECHO_IND_SEQ_EN
    eq_d.push_back(seq_m); eq_l.push_back(1'b0);
    seq_m++;
`endif
    eq_d.push_back(v); eq_l.push_back(1'b1);
  endtask

  task automatic call(input logic [31:0] v);
    echo__ENA = 1'b1; echo_v = v;
    step();
    echo__ENA = 1'b0;
  endtask

  // Consumer always ready: expects one word per cycle starting now.
  task automatic drain();
    logic [31:0] d;
    logic        l;
    msg_ready = 1'b1;
    while (eq_d.size() > 0) begin
      d = eq_d.pop_front(); l = eq_l.pop_front();
      chk("drain_valid", {31'd0, msg_valid}, 32'd1);
      chk("drain_data", msg_data, d);
      chk("drain_last", {31'd0, msg_last}, {31'd0, l});
      step();
    end
    chk("drain_idle", {31'd0, msg_valid}, 32'd0);
  endtask

  task automatic do_reset();
    nRST = 1'b0; echo__ENA = 1'b0; msg_ready = 1'b0;
    #2;
    chk("rst_rdy",   {31'd0, echo__RDY}, 32'd1);
    chk("rst_valid", {31'd0, msg_valid}, 32'd0);
    chk("rst_data",  msg_data, 32'd0);
    chk("rst_last",  {31'd0, msg_last}, 32'd0);
    chk("rst_drop",  {31'd0, drop_err}, 32'd0);
    eq_d.delete(); eq_l.delete(); seq_m = 32'd0;
    @(negedge CLK); nRST = 1'b1;
    step();
  endtask

  initial begin
    // Reset state
    do_reset();

    // 1: single call, consumer ready, header next cycle then payload
    msg_ready = 1'b1;
    call(32'd22);
    exp_msg(32'd22);
    chk("t1_rdy", {31'd0, echo__RDY}, 32'd1);
    drain();

    // 2: fill with 1..4 while stalled, 5th call dropped
    msg_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      call(i);
      exp_msg(i);
    end
    chk("t2_rdy_full", {31'd0, echo__RDY}, 32'd0);
    call(32'd5);
    chk("t2_drop", {31'd0, drop_err}, 32'd1);
    chk("t2_stall_valid", {31'd0, msg_valid}, 32'd1);
    chk("t2_stall_hdr", msg_data, HDR);
    drain();
    chk("t2_rdy_after", {31'd0, echo__RDY}, 32'd1);

    // 3: consumer ready toggles each cycle over 3 calls
    do_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (msg_valid) begin
        if (eq_d.size() == 0) chk("t3_extra_word", msg_data, 32'hDEAD_BEEF);
        else begin
          chk("t3_data", msg_data, eq_d[0]);
          chk("t3_last", {31'd0, msg_last}, {31'd0, eq_l[0]});
        end
      end
      msg_ready = cyc[0];
      if (msg_valid && msg_ready && eq_d.size() > 0) begin
        eq_d.pop_front(); eq_l.pop_front();
      end
      echo__ENA = (cyc < 3);
      echo_v    = 32'hA + cyc;
      if (cyc < 3) exp_msg(32'hA + cyc);
      step();
    end
    echo__ENA = 1'b0;
    chk("t3_all_words", eq_d.size(), 32'd0);
    chk("t3_idle", {31'd0, msg_valid}, 32'd0);

    // 4: full FIFO, pop and call in the same cycle
    do_reset();
    for (int i = 10; i <= 13; i++) begin
      call(i);
      exp_msg(i);
    end
    chk("t4_full", {31'd0, echo__RDY}, 32'd0);
    msg_ready = 1'b1;
    while (eq_l[0] == 1'b0) begin
      step();
      eq_d.pop_front(); eq_l.pop_front();
    end
    chk("t4_pay10", msg_data, eq_d.pop_front());
    void'(eq_l.pop_front());
    chk("t4_rdy_at_pop", {31'd0, echo__RDY}, 32'd0);
    echo__ENA = 1'b1; echo_v = 32'd99;
    step();
    echo__ENA = 1'b0; msg_ready = 1'b0;
    chk("t4_drop", {31'd0, drop_err}, 32'd1);
    chk("t4_rdy_next", {31'd0, echo__RDY}, 32'd1);
    call(32'd14);
    exp_msg(32'd14);
    chk("t4_write_ok", {31'd0, echo__RDY}, 32'd0);
    drain();

    // 5: reset between header and payload
    do_reset();
    call(32'h55);
    chk("t5_hdr_valid", {31'd0, msg_valid}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("t5_async_valid", {31'd0, msg_valid}, 32'd0);
    chk("t5_async_data", msg_data, 32'd0);
    chk("t5_async_rdy", {31'd0, echo__RDY}, 32'd1);
    @(negedge CLK); nRST = 1'b1;
    step(); step();
    chk("t5_empty", {31'd0, msg_valid}, 32'd0);
    msg_ready = 1'b1;
    call(32'h66);
    exp_msg(32'h66);
    drain();

`ifdef ECHO_IND_SEQ_EN
    // 6: sequence words, calls 7 and 9
    do_reset();
    msg_ready = 1'b1;
    echo__ENA = 1'b1; echo_v = 32'd7;
    step();
    chk("t6_w0", msg_data, 32'h0000_0002);
    echo_v = 32'd9;
    step();
    echo__ENA = 1'b0;
    chk("t6_w1", msg_data, 32'd0);
    chk("t6_l1", {31'd0, msg_last}, 32'd0);
    step();
    chk("t6_w2", msg_data, 32'd7);
    chk("t6_l2", {31'd0, msg_last}, 32'd1);
    step();
    chk("t6_w3", msg_data, 32'h0000_0002);
    step();
    chk("t6_w4", msg_data, 32'd1);
    step();
    chk("t6_w5", msg_data, 32'd9);
    chk("t6_l5", {31'd0, msg_last}, 32'd1);
    step();
    chk("t6_idle", {31'd0, msg_valid}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
